// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline types: hazard FSM states, stage control bundle, NOP encoding
package riscv_pkg;

  typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_FLUSH} hz_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_we;
  } hz_ctrl_t;

  // Canned control sets, field order pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we
  localparam hz_ctrl_t CTRL_RUN    = hz_ctrl_t'(5'b11001);
  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(5'b00000);
  localparam hz_ctrl_t CTRL_BRANCH = hz_ctrl_t'(5'b11111);
  localparam hz_ctrl_t CTRL_HOLD   = hz_ctrl_t'(5'b00011);

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - increment-enable counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - merges load-use, branch, dmem and imem stalls into per-stage enables/flushes
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_req,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  logic             r_pending_flush;
  logic             w_pending_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_mem_err;
  hz_ctrl_t         w_ctrl;
  logic             w_freeze;
  logic             w_timeout;
  logic             w_branch_go;

  always_comb begin
    w_ctrl        = CTRL_RUN;
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending_flush;
    w_timeout     = 1'b0;
    w_branch_go   = 1'b0;
    // Once parked in MEM_WAIT only dmem_ready can release the pipe
    w_freeze = (r_state == HZ_MEM_WAIT) ? !dmem_ready : (dmem_req_MEM && !dmem_ready);

    if (w_freeze) begin
      w_ctrl = CTRL_FREEZE;
      if ((r_state == HZ_MEM_WAIT) && (r_tmo_cnt == TMO_LAST)) begin
        w_timeout     = 1'b1;
        w_state_nxt   = HZ_RUN;
        w_pending_nxt = 1'b0;
      end else begin
        w_state_nxt = HZ_MEM_WAIT;
        if (r_state == HZ_FLUSH) begin
          w_pending_nxt = 1'b1;
        end
      end
    end else begin
      if (branch_taken_EX) begin
        w_ctrl      = CTRL_BRANCH;
        w_branch_go = 1'b1;
      end else if (load_use_req || !imem_ready) begin
        w_ctrl = CTRL_HOLD;
      end
      if (r_state == HZ_FLUSH) begin
        w_ctrl.ifid_flush = 1'b1;
      end
      w_state_nxt   = (w_branch_go || ((r_state == HZ_MEM_WAIT) && r_pending_flush)) ?
                      HZ_FLUSH : HZ_RUN;
      w_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= HZ_RUN;
      r_pending_flush <= 1'b0;
      r_tmo_cnt       <= '0;
      r_mem_err       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pending_flush <= w_pending_nxt;
      r_tmo_cnt       <= ((r_state == HZ_MEM_WAIT) && (w_state_nxt == HZ_MEM_WAIT)) ?
                         r_tmo_cnt + 1'b1 : '0;
      r_mem_err       <= r_mem_err | w_timeout;
    end
  end

  // Reset overrides the decode so the pipe free-runs without waiting for a clock edge
  assign pc_we       = reset | w_ctrl.pc_we;
  assign ifid_we     = reset | w_ctrl.ifid_we;
  assign exmem_we    = reset | w_ctrl.exmem_we;
  assign ifid_flush  = !reset & w_ctrl.ifid_flush;
  assign idex_bubble = !reset & w_ctrl.idex_bubble;
  assign mem_err     = r_mem_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_inc (!pc_we),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_inc (w_branch_go),
    .o_cnt (flush_cnt)
  );

endmodule
